// File: rtl/pipelined_add_const.sv
// Adds a constant to every beat in a valid/ready pipeline of STAGES registers.
// Stage 1 holds the sum. Later stages only delay it. Overflow beats are counted.
module pipelined_add_const #(
  parameter int unsigned     WIDTH    = 16,
  parameter longint unsigned ADDEND   = 1,
  parameter int unsigned     STAGES   = 2,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_bits,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_bits,
  output logic             io_out_overflow,
  output logic [7:0]       io_ovf_count
);

  localparam logic [WIDTH-1:0] ADDEND_W = WIDTH'(ADDEND);

  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_sum_data;
  logic               w_sum_ovf;

  logic [STAGES-1:0]  r_valid;
  logic [STAGES-1:0]  r_ovf;
  logic [WIDTH-1:0]   r_data [STAGES];
  logic [7:0]         r_ovf_count;

  logic [STAGES-1:0]  w_adv;
  logic [STAGES:0]    w_src_valid;
  logic [STAGES:0]    w_src_ovf;
  logic [WIDTH-1:0]   w_src_data [STAGES+1];

  assign w_sum      = {1'b0, io_in_bits} + {1'b0, ADDEND_W};
  assign w_sum_ovf  = w_sum[WIDTH];
  assign w_sum_data = (SATURATE && w_sum_ovf) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];

  // Source index 0 is the input port; index k+1 is the output of stage k.
  assign w_src_valid   = {r_valid, io_in_valid};
  assign w_src_ovf     = {r_ovf, w_sum_ovf};
  assign w_src_data[0] = w_sum_data;

  // A stage moves when any stage at or beyond it is empty, or the sink takes a beat.
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    assign w_src_data[g+1] = r_data[g];
    assign w_adv[g]        = io_out_ready || !(&r_valid[STAGES-1:g]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_adv[k]) r_valid[k] <= w_src_valid[k];
      end
    end
  end

  // Data and overflow bits are not reset; only the valid bits qualify them.
  always_ff @(posedge clock) begin
    for (int k = 0; k < STAGES; k++) begin
      if (w_adv[k]) begin
        r_data[k] <= w_src_data[k];
        r_ovf[k]  <= w_src_ovf[k];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ovf_count <= 8'd0;
    end else if (io_out_valid && io_out_ready && io_out_overflow && (r_ovf_count != 8'hFF)) begin
      r_ovf_count <= r_ovf_count + 8'd1;
    end
  end

  assign io_in_ready     = w_adv[0];
  assign io_out_valid    = r_valid[STAGES-1];
  assign io_out_bits     = r_data[STAGES-1];
  assign io_out_overflow = r_ovf[STAGES-1];
  assign io_ovf_count    = r_ovf_count;

endmodule

// File: tb/tb_pipelined_add_const.sv
// Directed bench for pipelined_add_const with three instances: wrap, saturate, and
// a four-stage pipeline using a large addend.
module tb_pipelined_add_const;

  logic        clock;
  logic        reset;
  logic        inValid;
  logic        inValidC;
  logic [15:0] inBits;
  logic        outReady;

  logic        inReadyA, outValidA, outOvfA;
  logic [15:0] outBitsA;
  logic [7:0]  ovfCountA;
  logic        inReadyB, outValidB, outOvfB;
  logic [15:0] outBitsB;
  logic [7:0]  ovfCountB;
  logic        inReadyC, outValidC, outOvfC;
  logic [15:0] outBitsC;
  logic [7:0]  ovfCountC;

  int checks   = 0;
  int failures = 0;

  pipelined_add_const #(.WIDTH(16), .ADDEND(1), .STAGES(2), .SATURATE(1'b0)) dutA (
    .clock(clock), .reset(reset),
    .io_in_valid(inValid), .io_in_ready(inReadyA), .io_in_bits(inBits),
    .io_out_valid(outValidA), .io_out_ready(outReady), .io_out_bits(outBitsA),
    .io_out_overflow(outOvfA), .io_ovf_count(ovfCountA)
  );

  pipelined_add_const #(.WIDTH(16), .ADDEND(1), .STAGES(2), .SATURATE(1'b1)) dutB (
    .clock(clock), .reset(reset),
    .io_in_valid(inValid), .io_in_ready(inReadyB), .io_in_bits(inBits),
    .io_out_valid(outValidB), .io_out_ready(outReady), .io_out_bits(outBitsB),
    .io_out_overflow(outOvfB), .io_ovf_count(ovfCountB)
  );

  pipelined_add_const #(.WIDTH(16), .ADDEND(64'h1234), .STAGES(4), .SATURATE(1'b0)) dutC (
    .clock(clock), .reset(reset),
    .io_in_valid(inValidC), .io_in_ready(inReadyC), .io_in_bits(inBits),
    .io_out_valid(outValidC), .io_out_ready(outReady), .io_out_bits(outBitsC),
    .io_out_overflow(outOvfC), .io_ovf_count(ovfCountC)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Sends one beat to all instances with the sink ready, then records each instance's
  // latency (edges since acceptance) and the first result it delivers.
  task automatic applyStimulus(input logic [15:0] value,
                               input logic [15:0] expA, input logic expOvfA,
                               input logic [15:0] expB, input logic [15:0] expC,
                               input logic expOvfC);
    int latA = 0, latB = 0, latC = 0;
    logic [15:0] bitsA = '0, bitsB = '0, bitsC = '0;
    logic ovfA = 1'b0, ovfB = 1'b0, ovfC = 1'b0;
    @(negedge clock);
    inValid = 1'b1; inValidC = 1'b1; inBits = value; outReady = 1'b1;
    #1;
    checkOutput("accept_ready_A", {63'd0, inReadyA}, 64'd1);
    checkOutput("accept_ready_C", {63'd0, inReadyC}, 64'd1);
    @(posedge clock);
    @(negedge clock);
    inValid = 1'b0; inValidC = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) @(negedge clock);
      if (outValidA && latA == 0) begin latA = c; bitsA = outBitsA; ovfA = outOvfA; end
      if (outValidB && latB == 0) begin latB = c; bitsB = outBitsB; ovfB = outOvfB; end
      if (outValidC && latC == 0) begin latC = c; bitsC = outBitsC; ovfC = outOvfC; end
    end
    checkOutput("latency_A", 64'(latA), 64'd2);
    checkOutput("bits_A", {48'd0, bitsA}, {48'd0, expA});
    checkOutput("ovf_A", {63'd0, ovfA}, {63'd0, expOvfA});
    checkOutput("latency_B", 64'(latB), 64'd2);
    checkOutput("bits_B", {48'd0, bitsB}, {48'd0, expB});
    checkOutput("ovf_B", {63'd0, ovfB}, {63'd0, expOvfA});
    checkOutput("latency_C", 64'(latC), 64'd4);
    checkOutput("bits_C", {48'd0, bitsC}, {48'd0, expC});
    checkOutput("ovf_C", {63'd0, ovfC}, {63'd0, expOvfC});
  endtask

  initial begin
    logic [15:0] got [3];
    int gotCycle [3];
    int nGot, accepted, stalls, seenValid;

    reset = 1'b1; inValid = 1'b0; inValidC = 1'b0; inBits = '0; outReady = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_valid_A", {63'd0, outValidA}, 64'd0);
    checkOutput("reset_valid_C", {63'd0, outValidC}, 64'd0);
    checkOutput("reset_count_A", {56'd0, ovfCountA}, 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("ready_after_reset", {63'd0, inReadyA}, 64'd1);

    applyStimulus(16'h0005, 16'h0006, 1'b0, 16'h0006, 16'h1239, 1'b0);
    checkOutput("count_no_ovf_A", {56'd0, ovfCountA}, 64'd0);
    applyStimulus(16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 16'h1233, 1'b1);
    checkOutput("count_after_ovf_A", {56'd0, ovfCountA}, 64'd1);
    checkOutput("count_after_ovf_B", {56'd0, ovfCountB}, 64'd1);
    checkOutput("count_after_ovf_C", {56'd0, ovfCountC}, 64'd1);
    applyStimulus(16'h0001, 16'h0002, 1'b0, 16'h0002, 16'h1235, 1'b0);

    // Backpressure: two beats fill the two-stage pipeline, the third must wait.
    @(negedge clock);
    outReady = 1'b0; inValid = 1'b1; inBits = 16'h0010;
    #1;
    checkOutput("bp_ready_0", {63'd0, inReadyA}, 64'd1);
    @(negedge clock);
    inBits = 16'h0011;
    #1;
    checkOutput("bp_ready_1", {63'd0, inReadyA}, 64'd1);
    @(negedge clock);
    inBits = 16'h0012;
    #1;
    checkOutput("bp_ready_full", {63'd0, inReadyA}, 64'd0);
    checkOutput("bp_head_valid", {63'd0, outValidA}, 64'd1);
    checkOutput("bp_head_bits", {48'd0, outBitsA}, 64'h11);
    @(negedge clock);
    checkOutput("bp_still_full", {63'd0, inReadyA}, 64'd0);
    checkOutput("bp_head_stable", {48'd0, outBitsA}, 64'h11);
    outReady = 1'b1;
    #1;
    checkOutput("bp_ready_release", {63'd0, inReadyA}, 64'd1);
    nGot = 0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clock);
      if (outValidA && nGot < 3) begin got[nGot] = outBitsA; gotCycle[nGot] = c; nGot++; end
      if (c == 0) begin
        @(posedge clock);
        @(negedge clock);
        inValid = 1'b0;
        if (outValidA && nGot < 3) begin got[nGot] = outBitsA; gotCycle[nGot] = c + 1; nGot++; end
        c++;
      end
    end
    checkOutput("bp_count", 64'(nGot), 64'd3);
    checkOutput("bp_out0", {48'd0, got[0]}, 64'h11);
    checkOutput("bp_out1", {48'd0, got[1]}, 64'h12);
    checkOutput("bp_out2", {48'd0, got[2]}, 64'h13);
    checkOutput("bp_gap01", 64'(gotCycle[1] - gotCycle[0]), 64'd1);
    checkOutput("bp_gap12", 64'(gotCycle[2] - gotCycle[1]), 64'd1);

    // Reset with two overflowing beats in flight.
    @(negedge clock);
    outReady = 1'b0; inValid = 1'b1; inBits = 16'hFFFF;
    @(negedge clock);
    inBits = 16'hFFFE;
    @(negedge clock);
    inValid = 1'b0;
    checkOutput("inflight_valid", {63'd0, outValidA}, 64'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; outReady = 1'b1;
    checkOutput("midreset_valid", {63'd0, outValidA}, 64'd0);
    checkOutput("midreset_count_A", {56'd0, ovfCountA}, 64'd0);
    checkOutput("midreset_count_B", {56'd0, ovfCountB}, 64'd0);
    seenValid = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (outValidA || outValidB) seenValid++;
    end
    checkOutput("no_stale_beat", 64'(seenValid), 64'd0);

    // Stream 256 overflowing beats; the counter must stop at 255.
    accepted = 0; stalls = 0;
    inValid = 1'b1; inBits = 16'hFFFF; outReady = 1'b1;
    for (int c = 0; c < 400 && accepted < 256; c++) begin
      #1;
      if (inReadyA) accepted++; else stalls++;
      @(negedge clock);
    end
    inValid = 1'b0;
    checkOutput("stream_accepted", 64'(accepted), 64'd256);
    checkOutput("stream_stalls", 64'(stalls), 64'd0);
    repeat (4) @(negedge clock);
    checkOutput("count_sat_A", {56'd0, ovfCountA}, 64'd255);
    checkOutput("count_sat_B", {56'd0, ovfCountB}, 64'd255);
    inValid = 1'b1;
    repeat (4) @(negedge clock);
    inValid = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("count_hold_A", {56'd0, ovfCountA}, 64'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
